// File: rtl/nts_tx_scheduler.sv
// nts_tx_scheduler
// Round-robin arbiter that shares the single TX MAC path among ENGINES NTS
// engines. One engine at a time is granted to the TX extractor; when the
// extractor reports done (or the watchdog expires) the engine is acknowledged
// with a one-cycle packet_read pulse and the pointer moves past it.
//
// Ports:
//   i_clk, i_areset            clock, asynchronous active-high reset
//   i_enable                   1 = new grants may be issued
//   i_timeout                  watchdog limit in cycles, 0 disables it
//   i_engine_packet_available  per-engine "tx packet ready"
//   o_engine_packet_read       one-cycle ack pulse to the engine just served
//   o_grant_valid              a grant is active
//   o_grant_index              index of the granted engine
//   o_grant_onehot             one-hot grant, all-zero when no grant
//   i_done                     extractor finished the granted packet
//   o_timeout_event            one-cycle pulse when the watchdog reclaims a grant
//   o_grant_count              total grants issued, wraps at 2^32
module nts_tx_scheduler #(
    parameter int unsigned ENGINES       = 2,
    parameter int unsigned TIMEOUT_WIDTH = 16,
    localparam int unsigned IDX_W        = (ENGINES > 1) ? $clog2(ENGINES) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_areset,
    input  logic                     i_enable,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
    input  logic [ENGINES-1:0]       i_engine_packet_available,
    output logic [ENGINES-1:0]       o_engine_packet_read,
    output logic                     o_grant_valid,
    output logic [IDX_W-1:0]         o_grant_index,
    output logic [ENGINES-1:0]       o_grant_onehot,
    input  logic                     i_done,
    output logic                     o_timeout_event,
    output logic [31:0]              o_grant_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    logic [1:0]               state, state_nxt;
    logic [IDX_W-1:0]         rr_ptr, rr_ptr_nxt;
    logic [TIMEOUT_WIDTH-1:0] timer, timer_nxt;
    logic [IDX_W-1:0]         index_nxt;
    logic                     valid_nxt;
    logic [ENGINES-1:0]       onehot_nxt;
    logic [ENGINES-1:0]       read_nxt;
    logic                     tev_nxt;
    logic [31:0]              count_nxt;

    logic                     sel_found;
    logic [IDX_W-1:0]         sel_idx;
    logic [ENGINES-1:0]       sel_onehot;
    int unsigned              cand;

    // Round-robin search: first available engine starting at rr_ptr, wrapping.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        cand       = 0;
        for (int unsigned i = 0; i < ENGINES; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= ENGINES) begin
                cand = cand - ENGINES;
            end
            if (!sel_found && i_engine_packet_available[IDX_W'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
        for (int unsigned i = 0; i < ENGINES; i++) begin
            sel_onehot[i] = (IDX_W'(i) == sel_idx);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        timer_nxt  = timer;
        index_nxt  = o_grant_index;
        valid_nxt  = o_grant_valid;
        onehot_nxt = o_grant_onehot;
        read_nxt   = '0;
        tev_nxt    = 1'b0;
        count_nxt  = o_grant_count;

        case (state)
            ST_IDLE: begin
                if (i_enable && sel_found) begin
                    state_nxt  = ST_BUSY;
                    index_nxt  = sel_idx;
                    valid_nxt  = 1'b1;
                    onehot_nxt = sel_onehot;
                    timer_nxt  = '0;
                    count_nxt  = o_grant_count + 32'd1;
                end
            end
            ST_BUSY: begin
                if (timer != {TIMEOUT_WIDTH{1'b1}}) begin
                    timer_nxt = timer + TIMEOUT_WIDTH'(1);
                end
                // Done takes priority over a simultaneous watchdog expiry.
                if (i_done) begin
                    state_nxt  = ST_RELEASE;
                    valid_nxt  = 1'b0;
                    onehot_nxt = '0;
                    read_nxt   = o_grant_onehot;
                end else if ((i_timeout != '0) &&
                             (timer == i_timeout - TIMEOUT_WIDTH'(1))) begin
                    state_nxt  = ST_RELEASE;
                    valid_nxt  = 1'b0;
                    onehot_nxt = '0;
                    read_nxt   = o_grant_onehot;
                    tev_nxt    = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (o_grant_index == IDX_W'(ENGINES - 1)) begin
                    rr_ptr_nxt = '0;
                end else begin
                    rr_ptr_nxt = o_grant_index + IDX_W'(1);
                end
                state_nxt = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                // Gives the served engine a cycle to drop its available flag.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state                <= ST_IDLE;
            rr_ptr               <= '0;
            timer                <= '0;
            o_grant_index        <= '0;
            o_grant_valid        <= 1'b0;
            o_grant_onehot       <= '0;
            o_engine_packet_read <= '0;
            o_timeout_event      <= 1'b0;
            o_grant_count        <= '0;
        end else begin
            state                <= state_nxt;
            rr_ptr               <= rr_ptr_nxt;
            timer                <= timer_nxt;
            o_grant_index        <= index_nxt;
            o_grant_valid        <= valid_nxt;
            o_grant_onehot       <= onehot_nxt;
            o_engine_packet_read <= read_nxt;
            o_timeout_event      <= tev_nxt;
            o_grant_count        <= count_nxt;
        end
    end

endmodule

// File: tb/tb_nts_tx_scheduler.sv
// Directed testbench for nts_tx_scheduler (ENGINES=2, TIMEOUT_WIDTH=16).
module tb_nts_tx_scheduler;

    localparam int unsigned ENGINES = 2;
    localparam int unsigned TW      = 16;
    localparam int unsigned IDX_W   = 1;

    logic               i_clk = 1'b0;
    logic               i_areset;
    logic               i_enable;
    logic [TW-1:0]      i_timeout;
    logic [ENGINES-1:0] avail;
    logic [ENGINES-1:0] pkt_read;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_index;
    logic [ENGINES-1:0] grant_onehot;
    logic               i_done;
    logic               timeout_event;
    logic [31:0]        grant_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 i_clk = ~i_clk;

    nts_tx_scheduler #(
        .ENGINES       (ENGINES),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .i_clk                     (i_clk),
        .i_areset                  (i_areset),
        .i_enable                  (i_enable),
        .i_timeout                 (i_timeout),
        .i_engine_packet_available (avail),
        .o_engine_packet_read      (pkt_read),
        .o_grant_valid             (grant_valid),
        .o_grant_index             (grant_index),
        .o_grant_onehot            (grant_onehot),
        .i_done                    (i_done),
        .o_timeout_event           (timeout_event),
        .o_grant_count             (grant_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_areset  = 1'b1;
        i_enable  = 1'b0;
        i_timeout = '0;
        avail     = '0;
        i_done    = 1'b0;
        tick();
        tick();
        i_areset = 1'b0;
    endtask

    // Bounded wait for a grant; reports the number of cycles it took.
    task automatic wait_grant(input string tag, output int cycles);
        cycles = 0;
        while (!grant_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        check_eq(tag, 32'(grant_valid), 32'd1);
    endtask

    int  cyc;
    int  pulses;
    logic flag;

    initial begin
        // 1: reset values, single grant, done -> ack
        do_reset();
        i_areset = 1'b1;
        #1;
        check_eq("rst_valid",  32'(grant_valid),   32'd0);
        check_eq("rst_onehot", 32'(grant_onehot),  32'd0);
        check_eq("rst_read",   32'(pkt_read),      32'd0);
        check_eq("rst_tev",    32'(timeout_event), 32'd0);
        check_eq("rst_count",  grant_count,        32'd0);
        tick();
        i_areset = 1'b0;
        i_enable = 1'b1;
        avail    = 2'b01;
        tick();
        check_eq("t1_valid",  32'(grant_valid),  32'd1);
        check_eq("t1_index",  32'(grant_index),  32'd0);
        check_eq("t1_onehot", 32'(grant_onehot), 32'h1);
        check_eq("t1_count",  grant_count,       32'd1);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        avail  = 2'b00;
        check_eq("t1_read",     32'(pkt_read),     32'h1);
        check_eq("t1_rel_vld",  32'(grant_valid),  32'd0);
        check_eq("t1_rel_oh",   32'(grant_onehot), 32'd0);
        tick();
        check_eq("t1_read_end", 32'(pkt_read),     32'd0);
        check_eq("t1_count2",   grant_count,       32'd1);

        // 2: both engines available, grants alternate, minimum spacing 4 cycles
        do_reset();
        i_enable = 1'b1;
        avail    = 2'b11;
        wait_grant("t2_first", cyc);
        check_eq("t2_first_lat", 32'(cyc), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check_eq("t2_index",  32'(grant_index),  32'(k % 2));
            check_eq("t2_onehot", 32'(grant_onehot), 32'(1) << (k % 2));
            tick();
            tick();
            i_done = 1'b1;
            tick();
            i_done = 1'b0;
            check_eq("t2_read", 32'(pkt_read), 32'(1) << (k % 2));
            if (k < 3) begin
                wait_grant("t2_next", cyc);
                check_eq("t2_spacing", 32'(cyc), 32'd3);
            end
        end
        check_eq("t2_count", grant_count, 32'd4);
        avail = 2'b00;
        tick();

        // 3: watchdog expiry after 5 busy cycles, then disabled watchdog
        do_reset();
        i_enable  = 1'b1;
        i_timeout = 16'd5;
        avail     = 2'b01;
        wait_grant("t3_grant", cyc);
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            flag = flag & grant_valid & ~timeout_event;
        end
        check_eq("t3_held5", 32'(flag), 32'd1);
        tick();
        check_eq("t3_tev",   32'(timeout_event), 32'd1);
        check_eq("t3_vld",   32'(grant_valid),   32'd0);
        check_eq("t3_read",  32'(pkt_read),      32'h1);
        tick();
        check_eq("t3_tev_end",  32'(timeout_event), 32'd0);
        check_eq("t3_read_end", 32'(pkt_read),      32'd0);
        i_timeout = '0;
        avail     = 2'b10;
        wait_grant("t3_grant2", cyc);
        check_eq("t3_index2", 32'(grant_index), 32'd1);
        flag = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            flag = flag & grant_valid & (grant_onehot == 2'b10) & ~timeout_event;
        end
        check_eq("t3_held1000", 32'(flag), 32'd1);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        avail  = 2'b00;
        check_eq("t3_read2", 32'(pkt_read), 32'h2);
        tick();

        // 4: done in the same cycle as watchdog expiry
        do_reset();
        i_enable  = 1'b1;
        i_timeout = 16'd3;
        avail     = 2'b01;
        wait_grant("t4_grant", cyc);
        tick();
        tick();
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        avail  = 2'b00;
        check_eq("t4_tev",  32'(timeout_event), 32'd0);
        check_eq("t4_read", 32'(pkt_read),      32'h1);
        pulses = (pkt_read != '0) ? 1 : 0;
        flag   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pkt_read != '0) pulses++;
            flag = flag | timeout_event;
        end
        check_eq("t4_one_read", 32'(pulses), 32'd1);
        check_eq("t4_no_tev",   32'(flag),   32'd0);

        // 5: enable gating
        do_reset();
        i_enable = 1'b0;
        avail    = 2'b11;
        flag     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            flag = flag | grant_valid;
        end
        check_eq("t5_no_grant", 32'(flag),  32'd0);
        check_eq("t5_count0",   grant_count, 32'd0);
        i_enable = 1'b1;
        wait_grant("t5_grant", cyc);
        check_eq("t5_index", 32'(grant_index), 32'd0);
        i_enable = 1'b0;
        tick();
        tick();
        check_eq("t5_still", 32'(grant_valid), 32'd1);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check_eq("t5_read", 32'(pkt_read), 32'h1);
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            flag = flag | grant_valid;
        end
        check_eq("t5_no_more", 32'(flag),   32'd0);
        check_eq("t5_count1",  grant_count, 32'd1);

        // 6: async reset during a grant to engine 1
        do_reset();
        i_enable = 1'b1;
        avail    = 2'b01;
        wait_grant("t6_grant0", cyc);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        avail  = 2'b11;
        wait_grant("t6_grant1", cyc);
        check_eq("t6_index1", 32'(grant_index), 32'd1);
        tick();
        #2;
        i_areset = 1'b1;
        #1;
        check_eq("t6_rst_vld",   32'(grant_valid),  32'd0);
        check_eq("t6_rst_oh",    32'(grant_onehot), 32'd0);
        check_eq("t6_rst_read",  32'(pkt_read),     32'd0);
        check_eq("t6_rst_count", grant_count,       32'd0);
        tick();
        i_areset = 1'b0;
        wait_grant("t6_grant_after", cyc);
        check_eq("t6_index0",  32'(grant_index),  32'd0);
        check_eq("t6_onehot0", 32'(grant_onehot), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
